// File: rtl/dram_cmd_sched.sv
// Single-request DRAM command sequencer: ACT/RD/WR/PRE with programmable spacing.
// Optional open-page policy when DRAM_OPEN_PAGE_EN is defined (closed-page otherwise).
module dram_cmd_sched #(
  parameter int DATA_WIDTH   = 1,
  parameter int NUM_OF_BANKS = 8,
  parameter int NUM_OF_ROWS  = 128,
  parameter int NUM_OF_COLS  = 8,
  parameter int T_RCD        = 2,
  parameter int T_RP         = 2,
  parameter int T_CL         = 2,
  parameter int T_WR         = 1,
  localparam int BANK_W = (NUM_OF_BANKS > 1) ? $clog2(NUM_OF_BANKS) : 1,
  localparam int ROW_W  = (NUM_OF_ROWS > 1) ? $clog2(NUM_OF_ROWS) : 1,
  localparam int COL_W  = (NUM_OF_COLS > 1) ? $clog2(NUM_OF_COLS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [BANK_W-1:0]       req_bank,
  input  logic [ROW_W-1:0]        req_row,
  input  logic [COL_W-1:0]        req_col,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  output logic                    cmd_valid,
  output logic [1:0]              cmd,
  output logic [NUM_OF_BANKS-1:0] cs,
  output logic [ROW_W-1:0]        cmd_row,
  output logic [COL_W-1:0]        cmd_col,
  output logic [DATA_WIDTH-1:0]   dram_data_out,
  input  logic [DATA_WIDTH-1:0]   dram_data_in,
  output logic                    rd_valid,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic [2:0]              dbg_state
);

  // Handshake: a request transfers on the rising edge where req_valid && req_ready;
  // req_ready is high only in IDLE outside reset, so at most one request is in flight.

  typedef enum logic [2:0] {
    S_IDLE, S_ACT, S_WAIT_RCD, S_RW, S_WAIT_DONE, S_PRE, S_WAIT_RP
  } state_e;

  localparam logic [1:0] CMD_ACT = 2'b00;
  localparam logic [1:0] CMD_RD  = 2'b01;
  localparam logic [1:0] CMD_WR  = 2'b10;
  localparam logic [1:0] CMD_PRE = 2'b11;

  localparam int T_MAX_A = (T_RCD > T_RP) ? T_RCD : T_RP;
  localparam int T_MAX_B = (T_CL > T_WR) ? T_CL : T_WR;
  localparam int T_MAX   = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
  localparam int CNT_W   = (T_MAX > 1) ? $clog2(T_MAX) : 1;

  localparam logic [CNT_W-1:0] LD_RCD = CNT_W'(T_RCD - 1);
  localparam logic [CNT_W-1:0] LD_RP  = CNT_W'(T_RP - 1);
  localparam logic [CNT_W-1:0] LD_CL  = CNT_W'(T_CL - 1);
  localparam logic [CNT_W-1:0] LD_WR  = CNT_W'(T_WR - 1);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    we_q;
  logic [BANK_W-1:0]       bank_q;
  logic [ROW_W-1:0]        row_q;
  logic [COL_W-1:0]        col_q;
  logic [DATA_WIDTH-1:0]   wdata_q;

  logic                    cmd_valid_q, cmd_valid_d;
  logic [1:0]              cmd_q, cmd_d;
  logic [NUM_OF_BANKS-1:0] cs_q, cs_d;
  logic [ROW_W-1:0]        cmd_row_q, cmd_row_d;
  logic [COL_W-1:0]        cmd_col_q, cmd_col_d;
  logic [DATA_WIDTH-1:0]   dout_q, dout_d;
  logic                    rd_valid_q, rd_valid_d;
  logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;

  logic                    accept;
  logic                    cnt_zero;
  logic                    cur_we;
  logic [BANK_W-1:0]       cur_bank;
  logic [ROW_W-1:0]        cur_row;
  logic [COL_W-1:0]        cur_col;
  logic [DATA_WIDTH-1:0]   cur_wdata;

  assign req_ready = (state_q == S_IDLE) && !rst;
  assign accept    = req_valid && req_ready;
  assign cnt_zero  = (cnt_q == '0);

  // The first command of a sequence is built from the live request, later ones from the latch.
  assign cur_we    = (state_q == S_IDLE) ? req_we    : we_q;
  assign cur_bank  = (state_q == S_IDLE) ? req_bank  : bank_q;
  assign cur_row   = (state_q == S_IDLE) ? req_row   : row_q;
  assign cur_col   = (state_q == S_IDLE) ? req_col   : col_q;
  assign cur_wdata = (state_q == S_IDLE) ? req_wdata : wdata_q;

`ifdef DRAM_OPEN_PAGE_EN
  logic [NUM_OF_BANKS-1:0] open_vld_q;
  logic [ROW_W-1:0]        open_row_q [NUM_OF_BANKS];
  logic                    page_hit;

  assign page_hit = open_vld_q[req_bank] && (open_row_q[req_bank] == req_row);

  always_ff @(posedge clk) begin
    if (rst) begin
      open_vld_q <= '0;
      for (int b = 0; b < NUM_OF_BANKS; b++) open_row_q[b] <= '0;
    end else if (state_q == S_ACT) begin
      open_vld_q[bank_q] <= 1'b1;
      open_row_q[bank_q] <= row_q;
    end else if (state_q == S_PRE) begin
      open_vld_q[bank_q] <= 1'b0;
    end
  end
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
`ifdef DRAM_OPEN_PAGE_EN
          if (page_hit)                    state_d = S_RW;
          else if (open_vld_q[req_bank])   state_d = S_PRE;
          else                             state_d = S_ACT;
`else
          state_d = S_ACT;
`endif
        end
      end
      S_ACT, S_WAIT_RCD: begin
        if (cnt_zero) state_d = S_RW;
        else begin
          state_d = S_WAIT_RCD;
          cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      S_RW, S_WAIT_DONE: begin
        if (cnt_zero) begin
          if (!we_q) begin
            rd_valid_d = 1'b1;
            rd_data_d  = dram_data_in;
          end
`ifdef DRAM_OPEN_PAGE_EN
          state_d = S_IDLE;
`else
          state_d = S_PRE;
`endif
        end else begin
          state_d = S_WAIT_DONE;
          cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      S_PRE, S_WAIT_RP: begin
        if (cnt_zero) begin
`ifdef DRAM_OPEN_PAGE_EN
          state_d = S_ACT;
`else
          state_d = S_IDLE;
`endif
        end else begin
          state_d = S_WAIT_RP;
          cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Command states last one cycle, so entering one is exactly one issued command.
    cmd_valid_d = 1'b0;
    cmd_d       = cmd_q;
    cs_d        = '0;
    cmd_row_d   = cmd_row_q;
    cmd_col_d   = cmd_col_q;
    dout_d      = dout_q;
    case (state_d)
      S_ACT: begin
        cnt_d          = LD_RCD;
        cmd_valid_d    = 1'b1;
        cmd_d          = CMD_ACT;
        cs_d[cur_bank] = 1'b1;
        cmd_row_d      = cur_row;
      end
      S_RW: begin
        cnt_d          = cur_we ? LD_WR : LD_CL;
        cmd_valid_d    = 1'b1;
        cmd_d          = cur_we ? CMD_WR : CMD_RD;
        cs_d[cur_bank] = 1'b1;
        cmd_col_d      = cur_col;
        if (cur_we) dout_d = cur_wdata;
      end
      S_PRE: begin
        cnt_d          = LD_RP;
        cmd_valid_d    = 1'b1;
        cmd_d          = CMD_PRE;
        cs_d[cur_bank] = 1'b1;
      end
      S_IDLE:  dout_d = '0;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      bank_q      <= '0;
      row_q       <= '0;
      col_q       <= '0;
      wdata_q     <= '0;
      cmd_valid_q <= 1'b0;
      cmd_q       <= '0;
      cs_q        <= '0;
      cmd_row_q   <= '0;
      cmd_col_q   <= '0;
      dout_q      <= '0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_q       <= cmd_d;
      cs_q        <= cs_d;
      cmd_row_q   <= cmd_row_d;
      cmd_col_q   <= cmd_col_d;
      dout_q      <= dout_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
      if (accept) begin
        we_q    <= req_we;
        bank_q  <= req_bank;
        row_q   <= req_row;
        col_q   <= req_col;
        wdata_q <= req_wdata;
      end
    end
  end

  assign cmd_valid     = cmd_valid_q;
  assign cmd           = cmd_q;
  assign cs            = cs_q;
  assign cmd_row       = cmd_row_q;
  assign cmd_col       = cmd_col_q;
  assign dram_data_out = dout_q;
  assign rd_valid      = rd_valid_q;
  assign rd_data       = rd_data_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_dram_cmd_sched.sv
// Directed bench for dram_cmd_sched: default-timing instance plus an all-ones timing instance.
// Expected commands and read returns are queued at request time and matched as they appear.
module tb_dram_cmd_sched;

  localparam int EW = 37;  // {cycle[15:0], cmd, cs[7:0], row[6:0], col[2:0], wdata}
  localparam int RW = 17;  // {cycle[15:0], data}

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       req_valid = 0, req_we = 0, req_wdata = 0, dram_data_in = 0;
  logic [2:0] req_bank = 0, req_col = 0;
  logic [6:0] req_row = 0;
  logic       req_ready, cmd_valid, dram_data_out, rd_valid, rd_data;
  logic [1:0] cmd;
  logic [7:0] cs;
  logic [6:0] cmd_row;
  logic [2:0] cmd_col, dbg_state;

  logic       f_req_valid = 0, f_req_we = 0, f_req_wdata = 0, f_dram_data_in = 0;
  logic [2:0] f_req_bank = 0, f_req_col = 0;
  logic [6:0] f_req_row = 0;
  logic       f_req_ready, f_cmd_valid, f_dram_data_out, f_rd_valid, f_rd_data;
  logic [1:0] f_cmd;
  logic [7:0] f_cs;
  logic [6:0] f_cmd_row;
  logic [2:0] f_cmd_col, f_dbg_state;

  dram_cmd_sched dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_bank(req_bank), .req_row(req_row), .req_col(req_col), .req_wdata(req_wdata),
    .cmd_valid(cmd_valid), .cmd(cmd), .cs(cs), .cmd_row(cmd_row), .cmd_col(cmd_col),
    .dram_data_out(dram_data_out), .dram_data_in(dram_data_in), .rd_valid(rd_valid),
    .rd_data(rd_data), .dbg_state(dbg_state)
  );

  dram_cmd_sched #(.T_RCD(1), .T_RP(1), .T_CL(1), .T_WR(1)) dut_fast (
    .clk(clk), .rst(rst), .req_valid(f_req_valid), .req_ready(f_req_ready), .req_we(f_req_we),
    .req_bank(f_req_bank), .req_row(f_req_row), .req_col(f_req_col), .req_wdata(f_req_wdata),
    .cmd_valid(f_cmd_valid), .cmd(f_cmd), .cs(f_cs), .cmd_row(f_cmd_row), .cmd_col(f_cmd_col),
    .dram_data_out(f_dram_data_out), .dram_data_in(f_dram_data_in), .rd_valid(f_rd_valid),
    .rd_data(f_rd_data), .dbg_state(f_dbg_state)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int a = 0;
  logic [EW-1:0] exp_q[$];
  logic [RW-1:0] rd_q[$];
  logic [EW-1:0] f_exp_q[$];
  logic [RW-1:0] f_rd_q[$];

  function automatic logic [EW-1:0] ent(input int c, input logic [1:0] k, input logic [7:0] s,
                                        input logic [6:0] r, input logic [2:0] cl, input logic w);
    return {c[15:0], k, s, r, cl, w};
  endfunction

  function automatic logic [RW-1:0] rent(input int c, input logic d);
    return {c[15:0], d};
  endfunction

  task automatic mon_main();
    logic [EW-1:0] obs, ex;
    logic [RW-1:0] robs, rex;
    if (cmd_valid) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        failures++;
        $error("FAIL cmd_unexpected cyc=%0d cmd=%0d cs=%h queued=%0d required>0", cyc, cmd, cs, exp_q.size());
      end
      if (exp_q.size() != 0) begin
        ex  = exp_q.pop_front();
        obs = {cyc[15:0], cmd, cs, (cmd == 2'b00) ? cmd_row : 7'd0,
               (cmd == 2'b01 || cmd == 2'b10) ? cmd_col : 3'd0, (cmd == 2'b10) ? dram_data_out : 1'b0};
        checks++;
        assert (obs === ex) else begin
          failures++;
          $error("FAIL cmd cyc=%0d observed=%h expected=%h", cyc, obs, ex);
        end
      end
    end else begin
      checks++;
      assert (cs === 8'h00) else begin
        failures++;
        $error("FAIL cs_idle cyc=%0d observed=%h expected=00", cyc, cs);
      end
    end
    if (rd_valid) begin
      checks++;
      assert (rd_q.size() != 0) else begin
        failures++;
        $error("FAIL rd_unexpected cyc=%0d rd_data=%0d", cyc, rd_data);
      end
      if (rd_q.size() != 0) begin
        rex  = rd_q.pop_front();
        robs = {cyc[15:0], rd_data};
        checks++;
        assert (robs === rex) else begin
          failures++;
          $error("FAIL rd cyc=%0d observed=%h expected=%h", cyc, robs, rex);
        end
      end
    end
  endtask

  task automatic mon_fast();
    logic [EW-1:0] obs, ex;
    logic [RW-1:0] robs, rex;
    if (f_cmd_valid) begin
      checks++;
      assert (f_exp_q.size() != 0) else begin
        failures++;
        $error("FAIL fast_cmd_unexpected cyc=%0d cmd=%0d cs=%h", cyc, f_cmd, f_cs);
      end
      if (f_exp_q.size() != 0) begin
        ex  = f_exp_q.pop_front();
        obs = {cyc[15:0], f_cmd, f_cs, (f_cmd == 2'b00) ? f_cmd_row : 7'd0,
               (f_cmd == 2'b01 || f_cmd == 2'b10) ? f_cmd_col : 3'd0, (f_cmd == 2'b10) ? f_dram_data_out : 1'b0};
        checks++;
        assert (obs === ex) else begin
          failures++;
          $error("FAIL fast_cmd cyc=%0d observed=%h expected=%h", cyc, obs, ex);
        end
      end
    end
    if (f_rd_valid) begin
      checks++;
      assert (f_rd_q.size() != 0) else begin
        failures++;
        $error("FAIL fast_rd_unexpected cyc=%0d rd_data=%0d", cyc, f_rd_data);
      end
      if (f_rd_q.size() != 0) begin
        rex  = f_rd_q.pop_front();
        robs = {cyc[15:0], f_rd_data};
        checks++;
        assert (robs === rex) else begin
          failures++;
          $error("FAIL fast_rd cyc=%0d observed=%h expected=%h", cyc, robs, rex);
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    mon_main();
    mon_fast();
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic chk_ready(input string tag, input logic obs, input logic ex);
    checks++;
    assert (obs === ex) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, ex);
    end
  endtask

  task automatic chk_zero(input string tag);
    checks++;
    assert ({cmd_valid, cmd, cs, cmd_row, cmd_col, dram_data_out, rd_valid, rd_data, dbg_state, req_ready} === 28'd0)
    else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%h expected=0", tag, cyc,
             {cmd_valid, cmd, cs, cmd_row, cmd_col, dram_data_out, rd_valid, rd_data, dbg_state, req_ready});
    end
  endtask

  task automatic wait_ready(output int acc);
    int n = 0;
    while (!req_ready && n < 50) begin
      tick();
      n++;
    end
    if (!req_ready) begin
      checks++;
      failures++;
      $error("FAIL ready_timeout cyc=%0d observed=0 expected=1", cyc);
    end
    acc = cyc;
  endtask

  task automatic f_wait_ready(output int acc);
    int n = 0;
    while (!f_req_ready && n < 50) begin
      tick();
      n++;
    end
    if (!f_req_ready) begin
      checks++;
      failures++;
      $error("FAIL fast_ready_timeout cyc=%0d observed=0 expected=1", cyc);
    end
    acc = cyc;
  endtask

  task automatic drive(input logic we, input logic [2:0] b, input logic [6:0] r,
                       input logic [2:0] c, input logic w);
    req_valid = 1'b1; req_we = we; req_bank = b; req_row = r; req_col = c; req_wdata = w;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic f_drive(input logic we, input logic [2:0] b, input logic [6:0] r,
                         input logic [2:0] c, input logic w);
    f_req_valid = 1'b1; f_req_we = we; f_req_bank = b; f_req_row = r; f_req_col = c; f_req_wdata = w;
    tick();
    f_req_valid = 1'b0;
  endtask

  initial begin
    // reset: outputs and req_ready held low
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_zero("reset_outputs");
      chk_ready("reset_fast_ready", f_req_ready, 1'b0);
    end
    rst = 1'b0;
    tick();
    chk_ready("ready_after_reset", req_ready, 1'b1);

`ifdef DRAM_OPEN_PAGE_EN
    // bank 2 row 10 closed -> ACT then RD, page stays open
    dram_data_in = 1'b1;
    wait_ready(a);
    exp_q.push_back(ent(a + 1, 2'b00, 8'h04, 7'd10, 3'd0, 1'b0));
    exp_q.push_back(ent(a + 3, 2'b01, 8'h04, 7'd0, 3'd1, 1'b0));
    rd_q.push_back(rent(a + 5, 1'b1));
    drive(1'b0, 3'd2, 7'd10, 3'd1, 1'b0);
    run_to(a + 5);
    chk_ready("open_ready_first", req_ready, 1'b1);

    // same row: hit, RD next cycle without ACT
    dram_data_in = 1'b0;
    wait_ready(a);
    exp_q.push_back(ent(a + 1, 2'b01, 8'h04, 7'd0, 3'd4, 1'b0));
    rd_q.push_back(rent(a + 3, 1'b0));
    drive(1'b0, 3'd2, 7'd10, 3'd4, 1'b0);
    run_to(a + 3);
    chk_ready("open_ready_hit", req_ready, 1'b1);

    // different row: miss, PRE then ACT then RD
    dram_data_in = 1'b1;
    wait_ready(a);
    exp_q.push_back(ent(a + 1, 2'b11, 8'h04, 7'd0, 3'd0, 1'b0));
    exp_q.push_back(ent(a + 3, 2'b00, 8'h04, 7'd11, 3'd0, 1'b0));
    exp_q.push_back(ent(a + 5, 2'b01, 8'h04, 7'd0, 3'd0, 1'b0));
    rd_q.push_back(rent(a + 7, 1'b1));
    drive(1'b0, 3'd2, 7'd11, 3'd0, 1'b0);
    run_to(a + 7);

    // bank 4 was never touched: still closed, so ACT first
    dram_data_in = 1'b0;
    wait_ready(a);
    exp_q.push_back(ent(a + 1, 2'b00, 8'h10, 7'd11, 3'd0, 1'b0));
    exp_q.push_back(ent(a + 3, 2'b01, 8'h10, 7'd0, 3'd2, 1'b0));
    rd_q.push_back(rent(a + 5, 1'b0));
    drive(1'b0, 3'd4, 7'd11, 3'd2, 1'b0);
    run_to(a + 5);

    // write hit on bank 2 row 11
    wait_ready(a);
    exp_q.push_back(ent(a + 1, 2'b10, 8'h04, 7'd0, 3'd3, 1'b1));
    drive(1'b1, 3'd2, 7'd11, 3'd3, 1'b1);
    run_to(a + 2);
    chk_ready("open_ready_write", req_ready, 1'b1);
`else
    // read bank 3 row 5 col 2
    dram_data_in = 1'b1;
    wait_ready(a);
    exp_q.push_back(ent(a + 1, 2'b00, 8'h08, 7'd5, 3'd0, 1'b0));
    exp_q.push_back(ent(a + 3, 2'b01, 8'h08, 7'd0, 3'd2, 1'b0));
    exp_q.push_back(ent(a + 5, 2'b11, 8'h08, 7'd0, 3'd0, 1'b0));
    rd_q.push_back(rent(a + 5, 1'b1));
    drive(1'b0, 3'd3, 7'd5, 3'd2, 1'b0);
    run_to(a + 6);
    chk_ready("read_ready_early", req_ready, 1'b0);
    tick();
    chk_ready("read_ready", req_ready, 1'b1);

    // write bank 0 row 127 col 7; dram_data_in left high, no read strobe allowed
    wait_ready(a);
    exp_q.push_back(ent(a + 1, 2'b00, 8'h01, 7'd127, 3'd0, 1'b0));
    exp_q.push_back(ent(a + 3, 2'b10, 8'h01, 7'd0, 3'd7, 1'b1));
    exp_q.push_back(ent(a + 4, 2'b11, 8'h01, 7'd0, 3'd0, 1'b0));
    drive(1'b1, 3'd0, 7'd127, 3'd7, 1'b1);
    run_to(a + 4);
    chk_ready("write_data_held", dram_data_out, 1'b1);
    run_to(a + 5);
    chk_ready("write_ready_early", req_ready, 1'b0);
    tick();
    chk_ready("write_ready", req_ready, 1'b1);

    // back-to-back reads with req_valid held high
    dram_data_in = 1'b0;
    wait_ready(a);
    exp_q.push_back(ent(a + 1, 2'b00, 8'h20, 7'd20, 3'd0, 1'b0));
    exp_q.push_back(ent(a + 3, 2'b01, 8'h20, 7'd0, 3'd4, 1'b0));
    exp_q.push_back(ent(a + 5, 2'b11, 8'h20, 7'd0, 3'd0, 1'b0));
    rd_q.push_back(rent(a + 5, 1'b0));
    exp_q.push_back(ent(a + 8, 2'b00, 8'h40, 7'd33, 3'd0, 1'b0));
    exp_q.push_back(ent(a + 10, 2'b01, 8'h40, 7'd0, 3'd1, 1'b0));
    exp_q.push_back(ent(a + 12, 2'b11, 8'h40, 7'd0, 3'd0, 1'b0));
    rd_q.push_back(rent(a + 12, 1'b1));
    req_valid = 1'b1; req_we = 1'b0; req_bank = 3'd5; req_row = 7'd20; req_col = 3'd4;
    tick();
    req_bank = 3'd6; req_row = 7'd33; req_col = 3'd1;
    run_to(a + 7);
    chk_ready("b2b_second_ready", req_ready, 1'b1);
    tick();
    req_valid = 1'b0;
    dram_data_in = 1'b1;
    run_to(a + 14);
    chk_ready("b2b_final_ready", req_ready, 1'b1);

    // reset in the middle of a read
    wait_ready(a);
    exp_q.push_back(ent(a + 1, 2'b00, 8'h02, 7'd2, 3'd0, 1'b0));
    drive(1'b0, 3'd1, 7'd2, 3'd3, 1'b0);
    run_to(a + 2);
    rst = 1'b1;
    tick();
    chk_zero("abort_outputs");
    rst = 1'b0;
    tick();
    chk_ready("abort_ready", req_ready, 1'b1);
    run_to(a + 12);

    // all-ones timing: read then write
    f_dram_data_in = 1'b1;
    f_wait_ready(a);
    f_exp_q.push_back(ent(a + 1, 2'b00, 8'h80, 7'd1, 3'd0, 1'b0));
    f_exp_q.push_back(ent(a + 2, 2'b01, 8'h80, 7'd0, 3'd5, 1'b0));
    f_exp_q.push_back(ent(a + 3, 2'b11, 8'h80, 7'd0, 3'd0, 1'b0));
    f_rd_q.push_back(rent(a + 3, 1'b1));
    f_drive(1'b0, 3'd7, 7'd1, 3'd5, 1'b0);
    run_to(a + 3);
    chk_ready("fast_read_ready_early", f_req_ready, 1'b0);
    tick();
    chk_ready("fast_read_ready", f_req_ready, 1'b1);

    f_wait_ready(a);
    f_exp_q.push_back(ent(a + 1, 2'b00, 8'h04, 7'd3, 3'd0, 1'b0));
    f_exp_q.push_back(ent(a + 2, 2'b10, 8'h04, 7'd0, 3'd6, 1'b1));
    f_exp_q.push_back(ent(a + 3, 2'b11, 8'h04, 7'd0, 3'd0, 1'b0));
    f_drive(1'b1, 3'd2, 7'd3, 3'd6, 1'b1);
    run_to(a + 4);
    chk_ready("fast_write_ready", f_req_ready, 1'b1);
`endif

    run_to(cyc + 6);
    checks++;
    assert ((exp_q.size() + rd_q.size() + f_exp_q.size() + f_rd_q.size()) === 0) else begin
      failures++;
      $error("FAIL drain observed=%0d/%0d/%0d/%0d expected=0", exp_q.size(), rd_q.size(),
             f_exp_q.size(), f_rd_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
